// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the program loader: FSM state values, UART command
// bytes and the default terminating instruction word.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int          BYTE_W        = 8;
   localparam int          LEN_DEF       = 32;
   localparam int          RAM_DEPTH_DEF = 2048;
   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;
   localparam logic [7:0] CMD_RUN_DEF  = 8'h52;
   localparam logic [7:0] CMD_STEP_DEF = 8'h53;
   localparam logic [7:0] CMD_NEXT_DEF = 8'h4E;

endpackage

// File: rtl/word_assembler.sv
// Shifts received bytes in MSB-first and strobes word_valid, combinationally,
// in the same cycle the fourth byte of a word arrives.
module word_assembler
   import fetch_ctrl_pkg::*;
#(
   parameter int LEN = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              valid,
   input  logic [BYTE_W-1:0] data,
   output logic [LEN-1:0]    word,
   output logic              word_valid
);

   logic [LEN-1:0] shift;
   logic [1:0]     count;

   assign word       = {shift[LEN-BYTE_W-1:0], data};
   assign word_valid = valid && (count == 2'd3);

   // The count wraps to 0 after the fourth byte, so words pack back to back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift <= '0;
         count <= 2'd0;
      end else if (clear) begin
         shift <= '0;
         count <= 2'd0;
      end else if (valid) begin
         shift <= word;
         count <= count + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader_ctrl.sv
// Loads a program from the debug UART into instruction memory, then gates
// the pipeline enable in continuous-run or single-step mode until halt.
module program_loader_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int             LEN               = LEN_DEF,
   parameter int             RAM_DEPTH_PROGRAM = RAM_DEPTH_DEF,
   parameter logic [LEN-1:0] HALT_WORD         = HALT_WORD_DEF,
   parameter logic [7:0]     CMD_LOAD          = CMD_LOAD_DEF,
   parameter logic [7:0]     CMD_RUN           = CMD_RUN_DEF,
   parameter logic [7:0]     CMD_STEP          = CMD_STEP_DEF,
   parameter logic [7:0]     CMD_NEXT          = CMD_NEXT_DEF
)(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [7:0]     i_rx_data,
   input  logic           i_rx_done,
   input  logic           i_halt,
   output logic           o_preload_flag,
   output logic [LEN-1:0] o_preload_address,
   output logic [LEN-1:0] o_preload_instruction,
   output logic           o_enable_pipeline,
   output logic [LEN-1:0] o_cycles,
   output logic [2:0]     o_state,
   output logic           o_done,
   output logic           o_error
);

   state_t         state, nxt_state;
   logic           loaded, nxt_loaded;
   logic [LEN-1:0] addr;
   logic [LEN-1:0] word;
   logic           word_valid;
   logic           asm_clear, asm_valid;
   logic           last_addr;
   logic           write, nxt_enable, nxt_error, clear_cycles;

   assign asm_clear = (state == ST_IDLE) && i_rx_done && (i_rx_data == CMD_LOAD);
   assign asm_valid = (state == ST_LOAD) && i_rx_done;
   assign last_addr = (addr == LEN'(RAM_DEPTH_PROGRAM - 1));
   assign o_state   = state;

   word_assembler #(.LEN(LEN)) u_word_assembler (
      .clk        (i_clk),
      .rst        (i_rst),
      .clear      (asm_clear),
      .valid      (asm_valid),
      .data       (i_rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      nxt_state    = state;
      nxt_loaded   = loaded;
      nxt_enable   = 1'b0;
      nxt_error    = 1'b0;
      write        = 1'b0;
      clear_cycles = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_rx_done) begin
               if (i_rx_data == CMD_LOAD) begin
                  nxt_state = ST_LOAD;
               end else if ((i_rx_data == CMD_RUN) && loaded) begin
                  nxt_state    = ST_RUN;
                  nxt_enable   = 1'b1;
                  clear_cycles = 1'b1;
               end else if ((i_rx_data == CMD_STEP) && loaded) begin
                  nxt_state    = ST_STEP;
                  clear_cycles = 1'b1;
               end else begin
                  nxt_error = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (word_valid) begin
               write = 1'b1;
               // A full memory without a halt word still counts as loaded,
               // but the truncation is flagged.
               if ((word == HALT_WORD) || last_addr) begin
                  nxt_state  = ST_IDLE;
                  nxt_loaded = 1'b1;
                  nxt_error  = (word != HALT_WORD);
               end
            end
         end
         ST_RUN: begin
            if (i_halt) nxt_state = ST_DONE;
            else        nxt_enable = 1'b1;
         end
         ST_STEP: begin
            // Halt takes priority over a coincident NEXT.
            if (i_halt)                                      nxt_state = ST_DONE;
            else if (i_rx_done && (i_rx_data == CMD_NEXT))  nxt_enable = 1'b1;
         end
         ST_DONE: begin
            nxt_state  = ST_IDLE;
            nxt_loaded = 1'b0;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state                 <= ST_IDLE;
         loaded                <= 1'b0;
         addr                  <= '0;
         o_preload_flag        <= 1'b0;
         o_preload_address     <= '0;
         o_preload_instruction <= '0;
         o_enable_pipeline     <= 1'b0;
         o_cycles              <= '0;
         o_done                <= 1'b0;
         o_error               <= 1'b0;
      end else begin
         state             <= nxt_state;
         loaded            <= nxt_loaded;
         o_preload_flag    <= write;
         o_enable_pipeline <= nxt_enable;
         o_done            <= (nxt_state == ST_DONE);
         o_error           <= nxt_error;
         if (write) begin
            o_preload_address     <= addr;
            o_preload_instruction <= word;
         end
         if (asm_clear)                addr <= '0;
         else if (write && !last_addr) addr <= addr + LEN'(1);
         // Counts cycles in which the pipeline was actually enabled.
         if (clear_cycles)
            o_cycles <= '0;
         else if (o_enable_pipeline && (o_cycles != '1))
            o_cycles <= o_cycles + LEN'(1);
      end
   end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Randomized bench for program_loader_ctrl against a transaction-level model
// of load, run and step sessions.
module tb_program_loader_ctrl;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
   localparam logic [7:0]  CMD_LOAD = 8'h4C;
   localparam logic [7:0]  CMD_RUN  = 8'h52;
   localparam logic [7:0]  CMD_STEP = 8'h53;
   localparam logic [7:0]  CMD_NEXT = 8'h4E;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        halt;
   logic        preload_flag;
   logic [31:0] preload_address;
   logic [31:0] preload_instruction;
   logic        enable_pipeline;
   logic [31:0] cycles;
   logic [2:0]  state;
   logic        done;
   logic        error;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   program_loader_ctrl #(.RAM_DEPTH_PROGRAM(DEPTH)) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .i_rx_data             (rx_data),
      .i_rx_done             (rx_done),
      .i_halt                (halt),
      .o_preload_flag        (preload_flag),
      .o_preload_address     (preload_address),
      .o_preload_instruction (preload_instruction),
      .o_enable_pipeline     (enable_pipeline),
      .o_cycles              (cycles),
      .o_state               (state),
      .o_done                (done),
      .o_error               (error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // monitor: records observed writes and counts pulses
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int unsigned n_err  = 0;
   int unsigned n_done = 0;
   int unsigned n_en   = 0;

   always @(negedge clk) begin
      if (preload_flag) begin
         obs_addr.push_back(preload_address);
         obs_data.push_back(preload_instruction);
      end
      if (error)           n_err++;
      if (done)            n_done++;
      if (enable_pipeline) n_en++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks (all start and end on a falling edge)
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic [31:0] tmp;
      tmp = w;
      for (int i = 0; i < 4; i++) begin
         send_byte(tmp[31:24]);
         tmp = tmp << 8;
         if (i < 3) tick($urandom_range(0, 1));
      end
   endtask

   // reference model + scoreboard for one load session
   logic [31:0] prog[DEPTH];

   task automatic load_program(input int n);
      logic [63:0] exp_q[$];
      int unsigned base_err;
      int          rd;
      int          exp_err;
      exp_err = 0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({32'(i), prog[i]});
         if (prog[i] == HALT) break;
         if (i == DEPTH - 1) begin
            exp_err = 1;
            break;
         end
      end
      base_err = n_err;
      rd       = obs_addr.size();
      send_byte(CMD_LOAD);
      for (int i = 0; i < n; i++) send_word(prog[i]);
      tick(2);
      check("load_count", 64'(obs_addr.size() - rd), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
         if (rd + j < obs_addr.size()) begin
            check("load_addr", 64'(obs_addr[rd+j]), 64'(exp_q[j][63:32]));
            check("load_data", 64'(obs_data[rd+j]), 64'(exp_q[j][31:0]));
         end
      end
      check("load_err", 64'(n_err - base_err), 64'(exp_err));
      check("load_state", 64'(state), 64'd0);
   endtask

   task automatic random_program();
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n - 1; i++) begin
         prog[i] = $urandom;
         if (prog[i] == HALT) prog[i] = 32'h0;
      end
      if (n < DEPTH)                       prog[n-1] = HALT;
      else if ($urandom_range(0, 3) == 0)  prog[n-1] = HALT;
      else                                 prog[n-1] = $urandom;
      load_program(n);
   endtask

   task automatic run_test(input int k);
      int unsigned b_en, b_done, b_err;
      b_en = n_en; b_done = n_done; b_err = n_err;
      send_byte(CMD_RUN);
      check("run_state", 64'(state), 64'd2);
      check("run_enable", 64'(enable_pipeline), 64'd1);
      for (int i = 1; i < k; i++) begin
         if (i == 2) send_byte($urandom_range(0, 255));
         else        tick(1);
      end
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      check("run_done_state", 64'(state), 64'd4);
      check("run_done_enable", 64'(enable_pipeline), 64'd0);
      tick(2);
      check("run_en_cycles", 64'(n_en - b_en), 64'(k));
      check("run_cycles", 64'(cycles), 64'(k));
      check("run_done_pulses", 64'(n_done - b_done), 64'd1);
      check("run_err", 64'(n_err - b_err), 64'd0);
      check("run_idle", 64'(state), 64'd0);
   endtask

   task automatic step_test(input int m);
      int unsigned b_en, b_done, b_err;
      logic [7:0]  junk;
      b_en = n_en; b_done = n_done; b_err = n_err;
      send_byte(CMD_STEP);
      check("step_state", 64'(state), 64'd3);
      check("step_enable", 64'(enable_pipeline), 64'd0);
      for (int i = 0; i < m; i++) begin
         tick($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == CMD_NEXT) junk = 8'h00;
            send_byte(junk);
         end
         send_byte(CMD_NEXT);
      end
      halt = 1'b1;
      send_byte(CMD_NEXT);
      halt = 1'b0;
      check("step_done_state", 64'(state), 64'd4);
      tick(2);
      check("step_pulses", 64'(n_en - b_en), 64'(m));
      check("step_cycles", 64'(cycles), 64'(m));
      check("step_done_pulses", 64'(n_done - b_done), 64'd1);
      check("step_err", 64'(n_err - b_err), 64'd0);
      check("step_idle", 64'(state), 64'd0);
   endtask

   task automatic idle_reject(input logic [7:0] b, input string tag);
      send_byte(b);
      check({tag, "_error"}, 64'(error), 64'd1);
      check({tag, "_state"}, 64'(state), 64'd0);
      check({tag, "_enable"}, 64'(enable_pipeline), 64'd0);
      tick(1);
   endtask

   initial begin
      rst     = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;
      halt    = 1'b0;
      #1;
      check("rst_state", 64'(state), 64'd0);
      check("rst_flag", 64'(preload_flag), 64'd0);
      check("rst_addr", 64'(preload_address), 64'd0);
      check("rst_instr", 64'(preload_instruction), 64'd0);
      check("rst_enable", 64'(enable_pipeline), 64'd0);
      check("rst_cycles", 64'(cycles), 64'd0);
      check("rst_done_err", 64'({done, error}), 64'd0);
      tick(2);
      rst = 1'b1;
      tick(1);

      // commands rejected before anything is loaded
      idle_reject(CMD_RUN, "run_unloaded");
      idle_reject(CMD_STEP, "step_unloaded");

      // directed two-word load
      prog[0] = 32'h0000_0001;
      prog[1] = HALT;
      load_program(2);

      run_test(10);
      idle_reject(CMD_RUN, "run_after_done");

      prog[0] = 32'h1234_5678;
      prog[1] = HALT;
      load_program(2);
      step_test(3);

      // truncated load fills the whole memory
      prog[0] = 32'hA5A5_0001;
      prog[1] = 32'h0BAD_F00D;
      prog[2] = 32'h0000_0000;
      prog[3] = 32'h7FFF_FFFF;
      load_program(4);
      run_test(3);

      // asynchronous reset in the middle of a word
      send_byte(CMD_LOAD);
      send_byte(8'hDE);
      send_byte(8'hAD);
      #2 rst = 1'b0;
      #1;
      check("midrst_state", 64'(state), 64'd0);
      check("midrst_flag", 64'(preload_flag), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      idle_reject(CMD_RUN, "run_after_reset");
      prog[0] = HALT;
      load_program(1);

      // randomized sessions
      for (int it = 0; it < 30; it++) begin
         random_program();
         if ($urandom_range(0, 1) == 1) run_test($urandom_range(1, 25));
         else                           step_test($urandom_range(0, 6));
         if ($urandom_range(0, 2) == 0) idle_reject((8'($urandom_range(0, 255)) == CMD_LOAD) ? 8'h00 : 8'($urandom_range(0, 255)), "idle_junk");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
